// File: rtl/bcd_pkg.sv
// Shared types and the per-digit add-3 helper for the binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

    // Double-dabble pre-shift correction: a digit of 5..9 becomes 8..12 so the
    // following left shift carries into the next decade.
    function automatic bcd_digit_t bcd_add3(bcd_digit_t d);
        bcd_digit_t r;
        if (d >= bcd_digit_t'(5)) begin
            r = d + bcd_digit_t'(3);
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational add-3 correction for one BCD digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t i_d,
    output bcd_digit_t o_d_c
);

    // Adjust is applied every SHIFT cycle ahead of the shift in the parent.
    assign o_d_c = bcd_add3(i_d);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), valid/ready on both sides.
// One bit of the binary word is consumed per SHIFT cycle; the result is held in
// DONE until the downstream side takes it.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf,
    output logic                  busy
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    b2b_state_t         r_state;
    logic [BCD_W-1:0]   r_bcd;
    logic [BIN_W-1:0]   r_bin;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic [BCD_W-1:0]   w_adj;

    // One add-3 corrector per output digit, applied to the current BCD register.
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_d   (r_bcd[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .o_d_c (w_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    // FSM, shift registers, bit counter and sticky truncation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin   <= in_bin;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The bit leaving the top digit is a lost 10**DIGITS carry.
                    {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                    r_ovf          <= r_ovf | w_adj[BCD_W-1];
                    r_cnt          <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(BIN_W - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status flags decode directly from the state register.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == SHIFT) || (r_state == DONE);
    assign out_bcd   = r_bcd;
    assign out_ovf   = r_ovf;

endmodule
